sync_fifo_level: RTL and testbench

Parametrised synchronous FIFO with occupancy count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. Successor to the UART byte FIFO: same push/pop handshake and first-word-fall-through read port, but it accepts simultaneous push/pop when full and exposes a level for flow control. It sits between the UART RX/TX datapaths and the debug-unit command logic.

---
 rtl/sync_fifo_level.sv | 107 ++++++++++
 tb/tb_sync_fifo_level.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_level.sv
// Synchronous FIFO with occupancy count, almost-full/almost-empty thresholds and
// sticky overflow/underflow flags; first-word-fall-through read port.
module sync_fifo_level #(
   parameter int DATA_LEN = 8,
   parameter int PTR_LEN  = 4,
   parameter int AF_LEVEL = 12,
   parameter int AE_LEVEL = 2
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_fifoWrite,
   input  logic [DATA_LEN-1:0] i_dataToWrite,
   input  logic                i_fifoRead,
   input  logic                i_clearErr,
   output logic [DATA_LEN-1:0] o_dataToRead,
   output logic                o_fifoEmpty,
   output logic                o_fifoFull,
   output logic                o_almostFull,
   output logic                o_almostEmpty,
   output logic [PTR_LEN:0]    o_count,
   output logic                o_overflow,
   output logic                o_underflow
);

   localparam int DEPTH = 2 ** PTR_LEN;
   localparam logic [PTR_LEN:0] DEPTH_CNT = (PTR_LEN + 1)'(DEPTH);
   localparam logic [PTR_LEN:0] AF_CNT    = (PTR_LEN + 1)'(AF_LEVEL);
   localparam logic [PTR_LEN:0] AE_CNT    = (PTR_LEN + 1)'(AE_LEVEL);

   logic [DATA_LEN-1:0] mem [DEPTH];

   logic [PTR_LEN-1:0] wrPtr_q, wrPtr_d;
   logic [PTR_LEN-1:0] rdPtr_q, rdPtr_d;
   logic [PTR_LEN:0]   count_q, count_d;
   logic               overflow_q, overflow_d;
   logic               underflow_q, underflow_d;

   logic isFull;
   logic isEmpty;
   logic pushOk;
   logic popOk;
   logic overflowSet;
   logic underflowSet;

   assign isFull  = (count_q == DEPTH_CNT);
   assign isEmpty = (count_q == '0);

   // A full FIFO still accepts a push when a pop frees the slot in the same cycle.
   assign pushOk       = i_fifoWrite && (!isFull || i_fifoRead);
   assign popOk        = i_fifoRead && !isEmpty;
   assign overflowSet  = i_fifoWrite && isFull && !i_fifoRead;
   assign underflowSet = i_fifoRead && isEmpty;

   always_comb begin
      wrPtr_d     = wrPtr_q;
      rdPtr_d     = rdPtr_q;
      count_d     = count_q;
      overflow_d  = overflowSet || (overflow_q && !i_clearErr);
      underflow_d = underflowSet || (underflow_q && !i_clearErr);

      if (pushOk) begin
         wrPtr_d = wrPtr_q + PTR_LEN'(1);
      end
      if (popOk) begin
         rdPtr_d = rdPtr_q + PTR_LEN'(1);
      end

      unique case ({pushOk, popOk})
         2'b10:   count_d = count_q + (PTR_LEN + 1)'(1);
         2'b01:   count_d = count_q - (PTR_LEN + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wrPtr_q     <= wrPtr_d;
         rdPtr_q     <= rdPtr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage carries no reset; contents are meaningless once the count drops to zero.
   always_ff @(posedge i_clk) begin
      if (pushOk && !i_reset) begin
         mem[wrPtr_q] <= i_dataToWrite;
      end
   end

   assign o_dataToRead  = mem[rdPtr_q];
   assign o_fifoEmpty   = isEmpty;
   assign o_fifoFull    = isFull;
   assign o_almostFull  = (count_q >= AF_CNT);
   assign o_almostEmpty = (count_q <= AE_CNT);
   assign o_count       = count_q;
   assign o_overflow    = overflow_q;
   assign o_underflow   = underflow_q;

endmodule

// File: tb/tb_sync_fifo_level.sv
// Self-checking bench for sync_fifo_level: directed sequences, a vector table and
// randomized traffic against a queue-based reference model.
module tb_sync_fifo_level;

   localparam int DATA_LEN = 8;
   localparam int PTR_LEN  = 4;
   localparam int DEPTH    = 16;
   localparam int AF_LEVEL = 12;
   localparam int AE_LEVEL = 2;

   logic                i_clk = 1'b0;
   logic                i_reset;
   logic                i_fifoWrite;
   logic [DATA_LEN-1:0] i_dataToWrite;
   logic                i_fifoRead;
   logic                i_clearErr;
   logic [DATA_LEN-1:0] o_dataToRead;
   logic                o_fifoEmpty;
   logic                o_fifoFull;
   logic                o_almostFull;
   logic                o_almostEmpty;
   logic [PTR_LEN:0]    o_count;
   logic                o_overflow;
   logic                o_underflow;

   int checks   = 0;
   int failures = 0;

   logic [DATA_LEN-1:0] modelQ[$];
   bit                  modelOver;
   bit                  modelUnder;

   typedef struct {
      bit                  wr;
      bit                  rd;
      bit                  clr;
      logic [DATA_LEN-1:0] data;
      int                  expCount;
      bit                  expEmpty;
      bit                  expAe;
      bit                  expUnder;
      bit                  expHeadValid;
      logic [DATA_LEN-1:0] expHead;
   } vec_t;

   vec_t vecs[12];

   always #5 i_clk = ~i_clk;

   sync_fifo_level #(
      .DATA_LEN(DATA_LEN),
      .PTR_LEN (PTR_LEN),
      .AF_LEVEL(AF_LEVEL),
      .AE_LEVEL(AE_LEVEL)
   ) dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_fifoWrite  (i_fifoWrite),
      .i_dataToWrite(i_dataToWrite),
      .i_fifoRead   (i_fifoRead),
      .i_clearErr   (i_clearErr),
      .o_dataToRead (o_dataToRead),
      .o_fifoEmpty  (o_fifoEmpty),
      .o_fifoFull   (o_fifoFull),
      .o_almostFull (o_almostFull),
      .o_almostEmpty(o_almostEmpty),
      .o_count      (o_count),
      .o_overflow   (o_overflow),
      .o_underflow  (o_underflow)
   );

   task automatic compare(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
      end
   endtask

   // Reference behaviour: a queue of words plus two sticky bits, driven by the acceptance rules.
   task automatic modelStep(input bit wr, input bit rd, input bit clr, input bit rst,
                            input logic [DATA_LEN-1:0] data);
      bit full;
      bit empty;
      bit setOver;
      bit setUnder;
      if (rst) begin
         modelQ.delete();
         modelOver  = 1'b0;
         modelUnder = 1'b0;
         return;
      end
      full     = (modelQ.size() == DEPTH);
      empty    = (modelQ.size() == 0);
      setOver  = wr && full && !rd;
      setUnder = rd && empty;
      if (rd && !empty) void'(modelQ.pop_front());
      if (wr && (!full || rd)) modelQ.push_back(data);
      modelOver  = setOver || (modelOver && !clr);
      modelUnder = setUnder || (modelUnder && !clr);
   endtask

   // Called at a falling edge; returns at the next falling edge with the model advanced.
   task automatic applyStimulus(input bit wr, input bit rd, input bit clr, input bit rst,
                                input logic [DATA_LEN-1:0] data,
                                output logic [DATA_LEN-1:0] popped);
      i_fifoWrite   = wr;
      i_fifoRead    = rd;
      i_clearErr    = clr;
      i_reset       = rst;
      i_dataToWrite = data;
      popped        = '0;
      #1;
      if (rd && !rst && modelQ.size() > 0) begin
         compare("headAtPop", int'(o_dataToRead), int'(modelQ[0]));
         popped = o_dataToRead;
      end
      @(posedge i_clk);
      modelStep(wr, rd, clr, rst, data);
      @(negedge i_clk);
   endtask

   task automatic step(input bit wr, input bit rd, input bit clr, input logic [DATA_LEN-1:0] data);
      logic [DATA_LEN-1:0] unused;
      applyStimulus(wr, rd, clr, 1'b0, data, unused);
   endtask

   task automatic checkOutput(input string tag);
      int n;
      n = modelQ.size();
      compare({tag, ".count"},     int'(o_count),       n);
      compare({tag, ".empty"},     int'(o_fifoEmpty),   int'(n == 0));
      compare({tag, ".full"},      int'(o_fifoFull),    int'(n == DEPTH));
      compare({tag, ".almFull"},   int'(o_almostFull),  int'(n >= AF_LEVEL));
      compare({tag, ".almEmpty"},  int'(o_almostEmpty), int'(n <= AE_LEVEL));
      compare({tag, ".overflow"},  int'(o_overflow),    int'(modelOver));
      compare({tag, ".underflow"}, int'(o_underflow),   int'(modelUnder));
      if (n > 0) compare({tag, ".head"}, int'(o_dataToRead), int'(modelQ[0]));
   endtask

   initial begin
      logic [DATA_LEN-1:0] popped;
      bit wr;
      bit rd;

      vecs[0]  = '{1, 1, 0, 8'h3C, 1, 0, 1, 1, 1, 8'h3C};
      vecs[1]  = '{0, 0, 1, 8'h00, 1, 0, 1, 0, 1, 8'h3C};
      vecs[2]  = '{0, 1, 0, 8'h00, 0, 1, 1, 0, 0, 8'h00};
      vecs[3]  = '{0, 1, 1, 8'h00, 0, 1, 1, 1, 0, 8'h00};
      vecs[4]  = '{0, 0, 1, 8'h00, 0, 1, 1, 0, 0, 8'h00};
      vecs[5]  = '{1, 0, 0, 8'h7E, 1, 0, 1, 0, 1, 8'h7E};
      vecs[6]  = '{1, 0, 0, 8'h81, 2, 0, 1, 0, 1, 8'h7E};
      vecs[7]  = '{1, 0, 0, 8'h92, 3, 0, 0, 0, 1, 8'h7E};
      vecs[8]  = '{0, 1, 0, 8'h00, 2, 0, 1, 0, 1, 8'h81};
      vecs[9]  = '{1, 1, 0, 8'hA5, 2, 0, 1, 0, 1, 8'h92};
      vecs[10] = '{0, 1, 0, 8'h00, 1, 0, 1, 0, 1, 8'hA5};
      vecs[11] = '{0, 1, 0, 8'h00, 0, 1, 1, 0, 0, 8'h00};

      i_reset       = 1'b1;
      i_fifoWrite   = 1'b0;
      i_fifoRead    = 1'b0;
      i_clearErr    = 1'b0;
      i_dataToWrite = '0;
      modelOver     = 1'b0;
      modelUnder    = 1'b0;
      @(negedge i_clk);
      applyStimulus(0, 0, 0, 1, 8'h00, popped);
      checkOutput("reset");
      compare("resetAlmostEmpty", int'(o_almostEmpty), 1);

      for (int i = 0; i < DEPTH; i++) begin
         step(1, 0, 0, 8'(i + 1));
         checkOutput("fill");
         compare("fillCount", int'(o_count), i + 1);
         compare("fillAlmostFull", int'(o_almostFull), int'(i + 1 >= 12));
         compare("fillFull", int'(o_fifoFull), int'(i + 1 == 16));
      end

      step(1, 0, 0, 8'hAA);
      checkOutput("overflow");
      compare("overflowFlag", int'(o_overflow), 1);
      compare("overflowCount", int'(o_count), 16);
      compare("overflowHead", int'(o_dataToRead), 8'h01);
      step(0, 0, 1, 8'h00);
      compare("overflowCleared", int'(o_overflow), 0);

      applyStimulus(1, 1, 0, 0, 8'h55, popped);
      checkOutput("fullPushPop");
      compare("fullPopOldest", int'(popped), 8'h01);
      compare("fullPushPopCount", int'(o_count), 16);
      compare("fullPushPopNoOverflow", int'(o_overflow), 0);

      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(0, 1, 0, 0, 8'h00, popped);
         checkOutput("drain");
         compare("drainOrder", int'(popped), (i < 15) ? (i + 2) : 8'h55);
      end
      compare("drainEmpty", int'(o_fifoEmpty), 1);

      for (int i = 0; i < 12; i++) begin
         step(vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].data);
         checkOutput("vecModel");
         compare($sformatf("vec%0d.count", i), int'(o_count), vecs[i].expCount);
         compare($sformatf("vec%0d.empty", i), int'(o_fifoEmpty), int'(vecs[i].expEmpty));
         compare($sformatf("vec%0d.almEmpty", i), int'(o_almostEmpty), int'(vecs[i].expAe));
         compare($sformatf("vec%0d.underflow", i), int'(o_underflow), int'(vecs[i].expUnder));
         if (vecs[i].expHeadValid)
            compare($sformatf("vec%0d.head", i), int'(o_dataToRead), int'(vecs[i].expHead));
      end

      for (int i = 0; i < 5; i++) begin
         step(1, 0, 0, 8'($urandom));
      end
      checkOutput("randPrefill");
      for (int i = 0; i < 40; i++) begin
         wr = 1'($urandom);
         rd = 1'($urandom);
         if (modelQ.size() <= 3) rd = 1'b0;
         if (modelQ.size() >= 10) wr = 1'b0;
         step(wr, rd, 0, 8'($urandom));
         checkOutput("random");
      end

      while (modelQ.size() > 0) step(0, 1, 0, 8'h00);
      step(0, 1, 0, 8'h00);
      compare("preResetUnderflow", int'(o_underflow), 1);
      for (int i = 0; i < 7; i++) step(1, 0, 0, 8'(8'hC0 + i));
      compare("preResetCount", int'(o_count), 7);
      applyStimulus(1, 1, 0, 1, 8'hEE, popped);
      checkOutput("midReset");
      compare("midResetCount", int'(o_count), 0);
      compare("midResetEmpty", int'(o_fifoEmpty), 1);
      compare("midResetUnderflow", int'(o_underflow), 0);
      compare("midResetOverflow", int'(o_overflow), 0);
      step(1, 0, 0, 8'h11);
      checkOutput("postResetPush");
      compare("postResetHead", int'(o_dataToRead), 8'h11);
      applyStimulus(0, 1, 0, 0, 8'h00, popped);
      checkOutput("postResetPop");
      compare("postResetPopped", int'(popped), 8'h11);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
